pwm_capture: RTL and testbench

- Receive-side counterpart of the motor PWM generator.
- Samples an incoming PWM/direction pair and measures high time and period in clk cycles.
- Recovers the 8-bit command word {dir, duty[6:0]}, with duty = floor(high*128/period).
- Used for loopback self-test of motor drive outputs and for decoding PWM commands from external controllers.

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_duty_div.sv | 66 ++++++
 rtl/pwm_capture.sv | 174 +++++++++++++++++
 tb/tb_pwm_capture.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM constants and the capture FSM state encoding.
package pwm_pkg;

  localparam int                DUTY_W   = 7;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 7'd127;
  localparam int                DIR_BIT  = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cap_state_t;

endpackage

// File: rtl/pwm_duty_div.sv
// Restoring unsigned divider producing a 7-bit duty quotient.
// start loads the operands, seven cycles each retire one quotient bit, and
// done is raised in the following cycle while the quotient is stable.
// A start during the done cycle reloads immediately.
module pwm_duty_div
  import pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W+6:0]  dividend,
  input  logic [CNT_W-1:0]  divisor,
  output logic              busy,
  output logic              done,
  output logic [DUTY_W-1:0] quotient
);

  logic [CNT_W-1:0]  rem;
  logic [CNT_W-1:0]  dvs;
  logic [DUTY_W-1:0] low;
  logic [DUTY_W-1:0] quo;
  logic [2:0]        step;
  logic [CNT_W:0]    trial;
  logic [CNT_W-1:0]  diff;
  logic              ge;

  // The partial remainder always stays below the divisor, so one extra bit
  // is enough to hold the shifted trial value.
  assign trial = {rem, low[DUTY_W-1]};
  assign ge    = (trial >= {1'b0, dvs});
  assign diff  = trial[CNT_W-1:0] - dvs;

  // Load, then shift-subtract one quotient bit per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      step <= 3'd0;
      rem  <= '0;
      dvs  <= '0;
      low  <= '0;
      quo  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      step <= 3'd0;
      rem  <= dividend[CNT_W+6:7];
      low  <= dividend[6:0];
      dvs  <= divisor;
      quo  <= '0;
    end else if (busy) begin
      if (step != 3'd7) begin
        step <= step + 3'd1;
        rem  <= ge ? diff : trial[CNT_W-1:0];
        low  <= {low[DUTY_W-2:0], 1'b0};
        quo  <= {quo[DUTY_W-2:0], ge};
      end else begin
        busy <= 1'b0;
      end
    end
  end

  assign done     = busy && (step == 3'd7);
  assign quotient = quo;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of a synchronized PWM input,
// recovers {dir, duty} and flags a stuck input after TIMEOUT idle cycles.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  input  logic             dir_in,
  output logic [7:0]       pwm_val_out,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             valid,
  output logic             stuck,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  logic pwm_p0, p_s, p_s_prev;
  logic dir_p0, d_s;
  logic [2:0] prime;
  logic rise, fall;

  cap_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [CNT_W-1:0] hi, hi_nxt;
  logic [CNT_W-1:0] hi_job, per_job;
  logic             dir_job;
  logic             start, drop, tmo, clr_stuck;

  logic              div_busy, div_done;
  logic [DUTY_W-1:0] div_q;

  // Two-flop synchronizers plus the previous sample for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_p0   <= 1'b0;
      p_s      <= 1'b0;
      p_s_prev <= 1'b0;
      dir_p0   <= 1'b0;
      d_s      <= 1'b0;
      prime    <= 3'b000;
    end else begin
      pwm_p0   <= pwm_in;
      p_s      <= pwm_p0;
      p_s_prev <= p_s;
      dir_p0   <= dir_in;
      d_s      <= dir_p0;
      prime    <= {prime[1:0], 1'b1};
    end
  end

  // Edges are trusted only once the synchronizer holds real samples, so a
  // line already high when reset releases is not mistaken for a fresh rise.
  assign rise    = prime[2] & p_s & ~p_s_prev;
  assign fall    = prime[2] & ~p_s & p_s_prev;
  assign cnt_inc = (cnt == TMO) ? cnt : cnt + CNT_W'(1);

  // Next-state logic: edge tracking, counting and timeout detection.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hi_nxt    = hi;
    start     = 1'b0;
    drop      = 1'b0;
    tmo       = 1'b0;
    clr_stuck = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          cnt_nxt   = CNT_W'(1);
          state_nxt = HIGH;
          clr_stuck = 1'b1;
        end
      end
      HIGH: begin
        if (fall) begin
          hi_nxt    = cnt;
          cnt_nxt   = cnt_inc;
          state_nxt = LOW;
        end else if (cnt == TMO) begin
          tmo       = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      LOW: begin
        if (rise) begin
          cnt_nxt   = CNT_W'(1);
          state_nxt = HIGH;
          // A divider finishing this cycle counts as free.
          if (!div_busy || div_done) start = 1'b1;
          else                       drop  = 1'b1;
        end else if (cnt == TMO) begin
          tmo       = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM, counter and the operands of the measurement being divided.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= '0;
      hi_job  <= '0;
      per_job <= '0;
      dir_job <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hi    <= hi_nxt;
      if (start) begin
        hi_job  <= hi;
        per_job <= cnt;
        dir_job <= d_s;
      end
    end
  end

  pwm_duty_div #(.CNT_W(CNT_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend ({hi, 7'd0}),
    .divisor  (cnt),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  // Output registers: timeout report or finished measurement, plus flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_val_out <= '0;
      high_cnt    <= '0;
      period_cnt  <= '0;
      valid       <= 1'b0;
      stuck       <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      valid   <= 1'b0;
      overrun <= drop;
      if (tmo) begin
        stuck                    <= 1'b1;
        pwm_val_out[DIR_BIT]     <= d_s;
        pwm_val_out[DUTY_W-1:0]  <= p_s ? DUTY_MAX : '0;
        high_cnt                 <= '0;
        period_cnt               <= '0;
        valid                    <= 1'b1;
      end else if (div_done) begin
        pwm_val_out[DIR_BIT]     <= dir_job;
        pwm_val_out[DUTY_W-1:0]  <= div_q;
        high_cnt                 <= hi_job;
        period_cnt               <= per_job;
        valid                    <= 1'b1;
      end
      if (clr_stuck) stuck <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture: drives PWM periods and compares every valid and
// overrun pulse against expectations built from the measurement rules.
module tb_pwm_capture;

  localparam int CNT_W = 16;
  localparam int TMO   = 1000;

  logic             clk = 1'b0;
  logic             reset;
  logic             pwm_in;
  logic             dir_in;
  logic [7:0]       pwm_val_out;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             valid;
  logic             stuck;
  logic             overrun;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .dir_in      (dir_in),
    .pwm_val_out (pwm_val_out),
    .high_cnt    (high_cnt),
    .period_cnt  (period_cnt),
    .valid       (valid),
    .stuck       (stuck),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int         cyc;
    logic [7:0] val;
    int         hi;
    int         per;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  int  obs_ovr[$];
  int  exp_ovr[$];

  int errors = 0;
  int checks = 0;

  // Reference model state: the open period and the last accepted divide.
  bit have_prev = 1'b0;
  int prev_c    = 0;
  int prev_hi   = 0;
  int last_acc  = -1000;

  always @(negedge clk) begin
    if (valid)   obs_q.push_back('{cyc: cyc, val: pwm_val_out, hi: int'(high_cnt), per: int'(period_cnt)});
    if (overrun) obs_ovr.push_back(cyc);
  end

  initial begin
    #800_000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    obs_q.delete(); exp_q.delete(); obs_ovr.delete(); exp_ovr.delete();
  endtask

  // A rise driven in cycle c is seen by the FSM in c+2; the divide result is
  // reported 9 cycles later, a dropped measurement one cycle after detection.
  task automatic model_rise(input bit dir);
    int c, det, per;
    c   = cyc;
    det = c + 2;
    if (have_prev) begin
      per = c - prev_c;
      if (det - last_acc >= 8) begin
        exp_q.push_back('{cyc: c + 11, val: {dir, 7'(prev_hi * 128 / per)}, hi: prev_hi, per: per});
        last_acc = det;
      end else begin
        exp_ovr.push_back(c + 3);
      end
    end
    have_prev = 1'b1;
    prev_c    = c;
  endtask

  task automatic pulse(input int hi, input int per, input bit dir);
    model_rise(dir);
    prev_hi = hi;
    pwm_in  = 1'b1;
    dir_in  = dir;
    tick(hi);
    pwm_in = 1'b0;
    tick(per - hi);
  endtask

  task automatic hold_low(input int n);
    if (have_prev) exp_q.push_back('{cyc: prev_c + 3 + TMO, val: {dir_in, 7'd0}, hi: 0, per: 0});
    have_prev = 1'b0;
    tick(n);
  endtask

  task automatic test_reset();
    reset = 1'b0; pwm_in = 1'b0; dir_in = 1'b0;
    tick(3);
    checks++; if (pwm_val_out !== 8'h00) begin errors++; $display("FAIL reset pwm_val_out got=%h want=00", pwm_val_out); end
    checks++; if (high_cnt !== '0)       begin errors++; $display("FAIL reset high_cnt got=%0d want=0", high_cnt); end
    checks++; if (period_cnt !== '0)     begin errors++; $display("FAIL reset period_cnt got=%0d want=0", period_cnt); end
    checks++; if ({valid, stuck, overrun} !== 3'b000) begin errors++; $display("FAIL reset flags got=%b want=000", {valid, stuck, overrun}); end
    reset = 1'b1;
    tick(5);
  endtask

  task automatic test_half_duty();
    clear_logs();
    for (int i = 0; i < 4; i++) pulse(64, 128, 1'b0);
    tick(20);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL half_duty valid_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL half_duty valid[%0d] got cyc=%0d val=%h hi=%0d per=%0d want cyc=%0d val=%h hi=%0d per=%0d", i, obs_q[i].cyc, obs_q[i].val, obs_q[i].hi, obs_q[i].per, exp_q[i].cyc, exp_q[i].val, exp_q[i].hi, exp_q[i].per); end
    end
    checks++;
    if (obs_ovr.size() !== exp_ovr.size()) begin errors++; $display("FAIL half_duty overrun_count got=%0d want=%0d", obs_ovr.size(), exp_ovr.size()); end
  endtask

  task automatic test_extremes();
    clear_logs();
    pulse(127, 128, 1'b1);
    pulse(127, 128, 1'b1);
    pulse(1, 128, 1'b1);
    pulse(1, 128, 1'b1);
    tick(20);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL extremes valid_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL extremes valid[%0d] got cyc=%0d val=%h hi=%0d per=%0d want cyc=%0d val=%h hi=%0d per=%0d", i, obs_q[i].cyc, obs_q[i].val, obs_q[i].hi, obs_q[i].per, exp_q[i].cyc, exp_q[i].val, exp_q[i].hi, exp_q[i].per); end
    end
  endtask

  task automatic test_ratios();
    clear_logs();
    pulse(32, 256, 1'b0);
    pulse(32, 256, 1'b0);
    pulse(100, 300, 1'b0);
    pulse(100, 300, 1'b0);
    tick(20);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL ratios valid_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL ratios valid[%0d] got cyc=%0d val=%h hi=%0d per=%0d want cyc=%0d val=%h hi=%0d per=%0d", i, obs_q[i].cyc, obs_q[i].val, obs_q[i].hi, obs_q[i].per, exp_q[i].cyc, exp_q[i].val, exp_q[i].hi, exp_q[i].per); end
    end
  endtask

  task automatic test_timeout();
    clear_logs();
    pulse(64, 128, 1'b1);
    pulse(64, 128, 1'b1);
    checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL timeout stuck_before got=%b want=0", stuck); end
    hold_low(TMO + 10);
    checks++; if (stuck !== 1'b1) begin errors++; $display("FAIL timeout stuck_set got=%b want=1", stuck); end
    pulse(64, 128, 1'b0);
    checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL timeout stuck_clear got=%b want=0", stuck); end
    pulse(64, 128, 1'b0);
    pulse(64, 128, 1'b0);
    tick(20);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL timeout valid_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL timeout valid[%0d] got cyc=%0d val=%h hi=%0d per=%0d want cyc=%0d val=%h hi=%0d per=%0d", i, obs_q[i].cyc, obs_q[i].val, obs_q[i].hi, obs_q[i].per, exp_q[i].cyc, exp_q[i].val, exp_q[i].hi, exp_q[i].per); end
    end
  endtask

  task automatic test_overrun();
    clear_logs();
    for (int i = 0; i < 6; i++) pulse(3, 6, 1'b0);
    for (int i = 0; i < 4; i++) pulse(4, 8, 1'b1);
    pulse(64, 128, 1'b0);
    tick(20);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL overrun valid_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL overrun valid[%0d] got cyc=%0d val=%h hi=%0d per=%0d want cyc=%0d val=%h hi=%0d per=%0d", i, obs_q[i].cyc, obs_q[i].val, obs_q[i].hi, obs_q[i].per, exp_q[i].cyc, exp_q[i].val, exp_q[i].hi, exp_q[i].per); end
    end
    checks++;
    if (obs_ovr.size() !== exp_ovr.size()) begin errors++; $display("FAIL overrun pulse_count got=%0d want=%0d", obs_ovr.size(), exp_ovr.size()); end
    for (int i = 0; i < exp_ovr.size() && i < obs_ovr.size(); i++) begin
      checks++;
      if (obs_ovr[i] !== exp_ovr[i]) begin errors++; $display("FAIL overrun pulse[%0d] got cyc=%0d want cyc=%0d", i, obs_ovr[i], exp_ovr[i]); end
    end
  endtask

  task automatic test_reset_mid();
    ev_t keep[$];
    int  keep_ovr[$];
    int  r;
    clear_logs();
    pulse(64, 128, 1'b0);
    model_rise(1'b0);
    pwm_in = 1'b1;
    tick(5);
    r = cyc;
    reset = 1'b0;
    #1;
    checks++; if (pwm_val_out !== 8'h00) begin errors++; $display("FAIL reset_mid pwm_val_out got=%h want=00", pwm_val_out); end
    checks++; if (high_cnt !== '0 || period_cnt !== '0) begin errors++; $display("FAIL reset_mid counts got hi=%0d per=%0d want 0 0", high_cnt, period_cnt); end
    checks++; if ({valid, stuck, overrun} !== 3'b000) begin errors++; $display("FAIL reset_mid flags got=%b want=000", {valid, stuck, overrun}); end
    foreach (exp_q[i]) if (exp_q[i].cyc <= r) keep.push_back(exp_q[i]);
    foreach (exp_ovr[i]) if (exp_ovr[i] <= r) keep_ovr.push_back(exp_ovr[i]);
    exp_q     = keep;
    exp_ovr   = keep_ovr;
    have_prev = 1'b0;
    last_acc  = -1000;
    tick(1);
    reset = 1'b1;
    tick(58);
    pwm_in = 1'b0;
    tick(64);
    for (int i = 0; i < 3; i++) pulse(64, 128, 1'b0);
    tick(20);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL reset_mid valid_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL reset_mid valid[%0d] got cyc=%0d val=%h hi=%0d per=%0d want cyc=%0d val=%h hi=%0d per=%0d", i, obs_q[i].cyc, obs_q[i].val, obs_q[i].hi, obs_q[i].per, exp_q[i].cyc, exp_q[i].val, exp_q[i].hi, exp_q[i].per); end
    end
  endtask

  task automatic test_random();
    int per, hi;
    bit dir;
    clear_logs();
    for (int i = 0; i < 30; i++) begin
      per = int'($urandom_range(200, 2));
      hi  = int'($urandom_range(per - 1, 1));
      dir = 1'($urandom_range(1, 0));
      pulse(hi, per, dir);
    end
    pulse(64, 128, 1'b0);
    tick(20);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL random valid_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL random valid[%0d] got cyc=%0d val=%h hi=%0d per=%0d want cyc=%0d val=%h hi=%0d per=%0d", i, obs_q[i].cyc, obs_q[i].val, obs_q[i].hi, obs_q[i].per, exp_q[i].cyc, exp_q[i].val, exp_q[i].hi, exp_q[i].per); end
    end
    checks++;
    if (obs_ovr.size() !== exp_ovr.size()) begin errors++; $display("FAIL random overrun_count got=%0d want=%0d", obs_ovr.size(), exp_ovr.size()); end
    for (int i = 0; i < exp_ovr.size() && i < obs_ovr.size(); i++) begin
      checks++;
      if (obs_ovr[i] !== exp_ovr[i]) begin errors++; $display("FAIL random overrun[%0d] got cyc=%0d want cyc=%0d", i, obs_ovr[i], exp_ovr[i]); end
    end
  endtask

  initial begin
    reset  = 1'b0;
    pwm_in = 1'b0;
    dir_in = 1'b0;
    test_reset();
    test_half_duty();
    test_extremes();
    test_ratios();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
